// File: rtl/id_ex_stage_pkg.sv
// Purpose : shared definitions for the ID/EX pipeline register and its hazard unit.
// Latency : n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: decode-control bit positions and packed view, forwarding select codes,
//           bubble control word, destination-register helper.
package id_ex_stage_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the 9-bit control word
    // {RegDst, ALUSrc, ALUOp[1:0], MemRead, MemWrite, Branch, MemtoReg, RegWrite}.
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 0;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // ALU operand source selects.
    localparam logic [1:0] FWD_REG = 2'b00;  // register-file read
    localparam logic [1:0] FWD_WB  = 2'b01;  // WB_WriteRegData
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM_ALUResult

    // A bubble carries no side effects: no register or memory write, no branch.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 9'h000;

    // Destination register of an instruction: rd for R-type, rt otherwise.
    function automatic logic [4:0] dest_reg(input logic reg_dst,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Purpose : load-use / data-hazard detection and next-cycle forwarding selects.
// Latency : purely combinational.
// Backpressure: stall=1 asks the caller to hold PC and IF/ID; a flush always wins (stall=0).
// Ports   : id_rs/id_rt decode sources; ex_* fields of the instruction now in EX;
//           mem_reg_write/mem_write_reg of the instruction in MEM; ex_flush squash;
//           stall, fwd1_d/fwd2_d next forwarding selects.
// Config  : ID_EX_FORWARD_EN defined -> forwarding + load-use stall only;
//           undefined -> no forwarding, stall on any EX/MEM producer match.
module hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_reg_dst,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_write_reg,
    input  logic       ex_flush,
    output logic       stall,
    output logic [1:0] fwd1_d,
    output logic [1:0] fwd2_d
);

    logic [4:0] ex_dest;
    assign ex_dest = dest_reg(ex_reg_dst, ex_rt, ex_rd);

`ifdef ID_EX_FORWARD_EN

    // EX producer is nearer in program order, so it is checked first.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       ex_wr,
                                           input logic [4:0] ex_dst,
                                           input logic       mem_wr,
                                           input logic [4:0] mem_dst);
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0) begin
            if (ex_wr && (ex_dst == src)) begin
                sel = FWD_MEM;
            end else if (mem_wr && (mem_dst == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    logic load_use;

    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_dest != 5'd0) &&
            ((ex_dest == id_rs) || (ex_dest == id_rt))) begin
            load_use = 1'b1;
        end
        stall  = load_use && !ex_flush;
        fwd1_d = fwd_sel(id_rs, ex_reg_write, ex_dest, mem_reg_write, mem_write_reg);
        fwd2_d = fwd_sel(id_rt, ex_reg_write, ex_dest, mem_reg_write, mem_write_reg);
    end

`else

    // Without forwarding, any in-flight producer of a source must drain to WB
    // (write-before-read register file) before the consumer may leave ID.
    function automatic logic src_hit(input logic [4:0] src,
                                     input logic       ex_wr,
                                     input logic [4:0] ex_dst,
                                     input logic       mem_wr,
                                     input logic [4:0] mem_dst);
        return (src != 5'd0) &&
               ((ex_wr && (ex_dst == src)) || (mem_wr && (mem_dst == src)));
    endfunction

    // A load also has RegWrite set, so it is covered by the generic match.
    logic unused_mem_read;
    assign unused_mem_read = ex_mem_read;

    always_comb begin
        stall  = (src_hit(id_rs, ex_reg_write, ex_dest, mem_reg_write, mem_write_reg) ||
                  src_hit(id_rt, ex_reg_write, ex_dest, mem_reg_write, mem_write_reg)) &&
                 !ex_flush;
        fwd1_d = FWD_REG;
        fwd2_d = FWD_REG;
    end

`endif

endmodule

// File: rtl/id_ex_stage.sv
// Purpose : ID/EX pipeline register of a 5-stage MIPS core with hazard handling.
// Latency : one cycle ID_* -> EX_*; Stall is combinational from ID and EX state.
// Backpressure: Stall=1 holds PC and IF/ID upstream while a bubble enters EX; EX_Flush overrides.
// Ports   : clk, rst_n (async, active-low); ID_* decode-stage values and controls;
//           MEM_RegWrite/MEM_WriteReg of the MEM-stage instruction; EX_Flush squash;
//           EX_* registered copies, EX_Forwarding1/2 operand selects; Stall.
// Config  : ID_EX_FORWARD_EN enables operand forwarding (see hazard_unit).
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ID_PC4,
    input  logic [31:0] ID_Order,
    input  logic [31:0] ID_ExtendOrder,
    input  logic [31:0] ID_ReadData1,
    input  logic [31:0] ID_ReadData2,
    input  logic [8:0]  ID_Ctrl,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        EX_Flush,
    output logic [31:0] EX_PC4,
    output logic [31:0] EX_Order,
    output logic [31:0] EX_ExtendOrder,
    output logic [31:0] EX_ReadData1,
    output logic [31:0] EX_ReadData2,
    output logic [8:0]  EX_Ctrl,
    output logic [1:0]  EX_Forwarding1,
    output logic [1:0]  EX_Forwarding2,
    output logic        Stall
);

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] order_q, order_d;
    logic [31:0] ext_q, ext_d;
    logic [31:0] rd1_q, rd1_d;
    logic [31:0] rd2_q, rd2_d;
    logic [8:0]  ctrl_q, ctrl_d;
    logic [1:0]  fwd1_q, fwd1_d;
    logic [1:0]  fwd2_q, fwd2_d;

    logic [1:0]  fwd1_next;
    logic [1:0]  fwd2_next;
    logic        stall;

    hazard_unit u_hazard (
        .id_rs         (ID_Order[25:21]),
        .id_rt         (ID_Order[20:16]),
        .ex_reg_dst    (ctrl_q[CTRL_REGDST]),
        .ex_mem_read   (ctrl_q[CTRL_MEMREAD]),
        .ex_reg_write  (ctrl_q[CTRL_REGWRITE]),
        .ex_rt         (order_q[20:16]),
        .ex_rd         (order_q[15:11]),
        .mem_reg_write (MEM_RegWrite),
        .mem_write_reg (MEM_WriteReg),
        .ex_flush      (EX_Flush),
        .stall         (stall),
        .fwd1_d        (fwd1_next),
        .fwd2_d        (fwd2_next)
    );

    // Data fields are captured unconditionally: in a bubble they are
    // don't-care because the zeroed controls suppress every side effect.
    always_comb begin
        pc4_d   = ID_PC4;
        order_d = ID_Order;
        ext_d   = ID_ExtendOrder;
        rd1_d   = ID_ReadData1;
        rd2_d   = ID_ReadData2;
        ctrl_d  = ID_Ctrl;
        fwd1_d  = fwd1_next;
        fwd2_d  = fwd2_next;
        // stall is already forced low by a flush, so both cases reduce to a bubble.
        if (EX_Flush || stall) begin
            ctrl_d = CTRL_BUBBLE;
            fwd1_d = FWD_REG;
            fwd2_d = FWD_REG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q   <= '0;
            order_q <= '0;
            ext_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            fwd1_q  <= FWD_REG;
            fwd2_q  <= FWD_REG;
        end else begin
            pc4_q   <= pc4_d;
            order_q <= order_d;
            ext_q   <= ext_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ctrl_q  <= ctrl_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
        end
    end

    assign EX_PC4         = pc4_q;
    assign EX_Order       = order_q;
    assign EX_ExtendOrder = ext_q;
    assign EX_ReadData1   = rd1_q;
    assign EX_ReadData2   = rd2_q;
    assign EX_Ctrl        = ctrl_q;
    assign EX_Forwarding1 = fwd1_q;
    assign EX_Forwarding2 = fwd2_q;
    assign Stall          = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Purpose : directed scoreboard bench for id_ex_stage (either ID_EX_FORWARD_EN build).
// Latency : expectations are tagged with the cycle in which they must be visible.
// Backpressure: n/a; the driver and the negedge monitor communicate only through queues.
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam logic [8:0] C_LW  = 9'h093;  // ALUSrc MemRead MemtoReg RegWrite
    localparam logic [8:0] C_ADD = 9'h141;  // RegDst ALUOp=10 RegWrite
    localparam logic [8:0] C_SW  = 9'h088;  // ALUSrc MemWrite

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ID_PC4 = '0, ID_Order = '0, ID_ExtendOrder = '0;
    logic [31:0] ID_ReadData1 = '0, ID_ReadData2 = '0;
    logic [8:0]  ID_Ctrl = '0;
    logic        MEM_RegWrite = 1'b0;
    logic [4:0]  MEM_WriteReg = '0;
    logic        EX_Flush = 1'b0;
    logic [31:0] EX_PC4, EX_Order, EX_ExtendOrder, EX_ReadData1, EX_ReadData2;
    logic [8:0]  EX_Ctrl;
    logic [1:0]  EX_Forwarding1, EX_Forwarding2;
    logic        Stall;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ID_PC4(ID_PC4), .ID_Order(ID_Order), .ID_ExtendOrder(ID_ExtendOrder),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Ctrl(ID_Ctrl),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .EX_Flush(EX_Flush),
        .EX_PC4(EX_PC4), .EX_Order(EX_Order), .EX_ExtendOrder(EX_ExtendOrder),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Ctrl(EX_Ctrl),
        .EX_Forwarding1(EX_Forwarding1), .EX_Forwarding2(EX_Forwarding2), .Stall(Stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        logic [8:0]  ctrl;
        logic [1:0]  f1, f2;
        logic [31:0] pc4, order, ext, rd1, rd2;
    } ex_exp_t;

    typedef struct {
        int   tag;
        logic stall;
    } st_exp_t;

    ex_exp_t ex_q[$];
    st_exp_t st_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] v_pc4(input int n);   return 32'h0040_0000 + 32'(n * 4); endfunction
    function automatic logic [31:0] v_ext(input int n);   return 32'hFFFF_0000 | 32'(n);     endfunction
    function automatic logic [31:0] v_rd1(input int n);   return 32'hA000_0000 + 32'(n);     endfunction
    function automatic logic [31:0] v_rd2(input int n);   return 32'hB000_0000 + 32'(n);     endfunction
    function automatic logic [31:0] v_order(input int n, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd);
        return {6'(n), rs, rt, rd, 11'(n)};
    endfunction

    // Monitor: compares whatever expectation is due in the current cycle.
    always @(negedge clk) begin
        st_exp_t se;
        ex_exp_t ee;
        if (st_q.size() > 0 && st_q[0].tag == cyc) begin
            se = st_q.pop_front();
            n_checks++;
            if (Stall === se.stall) n_pass++;
            else $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, Stall, se.stall);
        end
        if (ex_q.size() > 0 && ex_q[0].tag == cyc) begin
            ee = ex_q.pop_front();
            n_checks++;
            if (EX_Ctrl === ee.ctrl && EX_Forwarding1 === ee.f1 && EX_Forwarding2 === ee.f2 &&
                EX_PC4 === ee.pc4 && EX_Order === ee.order && EX_ExtendOrder === ee.ext &&
                EX_ReadData1 === ee.rd1 && EX_ReadData2 === ee.rd2) begin
                n_pass++;
            end else begin
                $display("FAIL ex_regs cyc=%0d got ctrl=%h f1=%b f2=%b pc4=%h ord=%h ext=%h rd1=%h rd2=%h exp ctrl=%h f1=%b f2=%b pc4=%h ord=%h ext=%h rd1=%h rd2=%h",
                         cyc, EX_Ctrl, EX_Forwarding1, EX_Forwarding2, EX_PC4, EX_Order,
                         EX_ExtendOrder, EX_ReadData1, EX_ReadData2, ee.ctrl, ee.f1, ee.f2,
                         ee.pc4, ee.order, ee.ext, ee.rd1, ee.rd2);
            end
        end
    end

    // Apply one ID-stage vector just after a rising edge and queue its expected
    // Stall (this cycle) and EX contents (after the next edge).
    task automatic drive(input int n, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [8:0] ctrl,
                         input logic mrw, input logic [4:0] mwr, input logic flush,
                         input logic exp_stall, input logic [8:0] exp_ctrl,
                         input logic [1:0] ef1, input logic [1:0] ef2, input bit push_ex);
        st_exp_t se;
        ex_exp_t ee;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        ID_PC4         = v_pc4(n);
        ID_Order       = v_order(n, rs, rt, rd);
        ID_ExtendOrder = v_ext(n);
        ID_ReadData1   = v_rd1(n);
        ID_ReadData2   = v_rd2(n);
        ID_Ctrl        = ctrl;
        MEM_RegWrite   = mrw;
        MEM_WriteReg   = mwr;
        EX_Flush       = flush;
        se.tag = cyc; se.stall = exp_stall;
        st_q.push_back(se);
        if (push_ex) begin
            ee.tag = cyc + 1; ee.ctrl = exp_ctrl; ee.f1 = ef1; ee.f2 = ef2;
            ee.pc4 = v_pc4(n); ee.order = v_order(n, rs, rt, rd);
            ee.ext = v_ext(n); ee.rd1 = v_rd1(n); ee.rd2 = v_rd2(n);
            ex_q.push_back(ee);
        end
    endtask

    task automatic expect_reset_state();
        st_exp_t se;
        ex_exp_t ee;
        se.tag = cyc; se.stall = 1'b0;
        st_q.push_back(se);
        ee.tag = cyc; ee.ctrl = '0; ee.f1 = 2'b00; ee.f2 = 2'b00;
        ee.pc4 = '0; ee.order = '0; ee.ext = '0; ee.rd1 = '0; ee.rd2 = '0;
        ex_q.push_back(ee);
    endtask

    initial begin
        ex_exp_t ee;
        // Reset with every control bit set on the ID side.
        @(posedge clk);
        #1;
        ID_Ctrl  = 9'h1FF;
        ID_Order = v_order(0, 5'd8, 5'd8, 5'd8);
        ID_PC4   = 32'hDEAD_BEEF;
        expect_reset_state();

        // lw $8 then a dependent add: load-use stall inserts one bubble.
        drive(1, 5'd1, 5'd8, 5'd0,  C_LW,  1'b0, 5'd0, 1'b0, 1'b0, C_LW, 2'b00, 2'b00, 1'b1);
        drive(2, 5'd8, 5'd2, 5'd10, C_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b1);
`ifdef ID_EX_FORWARD_EN
        drive(3, 5'd8, 5'd2, 5'd10, C_ADD, 1'b1, 5'd8, 1'b0, 1'b0, C_ADD, 2'b01, 2'b00, 1'b1);
        // EX add $10 and MEM writing $10: EX match wins for rt.
        drive(5, 5'd3, 5'd10, 5'd11, C_ADD, 1'b1, 5'd10, 1'b0, 1'b0, C_ADD, 2'b00, 2'b10, 1'b1);
`else
        drive(3, 5'd8, 5'd2, 5'd10, C_ADD, 1'b1, 5'd8, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b1);
        drive(4, 5'd8, 5'd2, 5'd10, C_ADD, 1'b0, 5'd0, 1'b0, 1'b0, C_ADD, 2'b00, 2'b00, 1'b1);
        drive(5, 5'd3, 5'd10, 5'd11, C_ADD, 1'b1, 5'd10, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b1);
        drive(6, 5'd3, 5'd10, 5'd11, C_ADD, 1'b1, 5'd10, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b1);
        drive(7, 5'd3, 5'd10, 5'd11, C_ADD, 1'b0, 5'd0, 1'b0, 1'b0, C_ADD, 2'b00, 2'b00, 1'b1);
`endif
        // MEM writing $0 never forwards or stalls.
        drive(8, 5'd0, 5'd0, 5'd12, C_ADD, 1'b1, 5'd0, 1'b0, 1'b0, C_ADD, 2'b00, 2'b00, 1'b1);
        drive(9, 5'd4, 5'd13, 5'd0, C_LW,  1'b0, 5'd0, 1'b0, 1'b0, C_LW,  2'b00, 2'b00, 1'b1);
        // Load-use with simultaneous flush: no stall, bubble enters EX.
        drive(10, 5'd13, 5'd13, 5'd14, C_ADD, 1'b0, 5'd0, 1'b1, 1'b0, 9'h0, 2'b00, 2'b00, 1'b1);
`ifdef ID_EX_FORWARD_EN
        drive(11, 5'd5, 5'd6, 5'd0, C_SW, 1'b1, 5'd5, 1'b0, 1'b0, C_SW, 2'b01, 2'b00, 1'b1);
`else
        drive(11, 5'd5, 5'd6, 5'd0, C_SW, 1'b1, 5'd5, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b1);
`endif
        drive(12, 5'd5, 5'd6, 5'd0, C_SW,  1'b0, 5'd0, 1'b0, 1'b0, C_SW,  2'b00, 2'b00, 1'b1);
        // EX instruction writing $0 must not match sources $0.
        drive(13, 5'd1, 5'd2, 5'd0, C_ADD, 1'b0, 5'd0, 1'b0, 1'b0, C_ADD, 2'b00, 2'b00, 1'b1);
        drive(14, 5'd0, 5'd0, 5'd3, C_ADD, 1'b0, 5'd0, 1'b0, 1'b0, C_ADD, 2'b00, 2'b00, 1'b1);
        // Reset during a load-use stall, then normal capture after release.
        drive(15, 5'd1, 5'd8, 5'd0,  C_LW,  1'b0, 5'd0, 1'b0, 1'b0, C_LW, 2'b00, 2'b00, 1'b1);
        drive(16, 5'd8, 5'd2, 5'd10, C_ADD, 1'b0, 5'd0, 1'b0, 1'b1, 9'h0, 2'b00, 2'b00, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_reset_state();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ee.tag = cyc + 1; ee.ctrl = C_ADD; ee.f1 = 2'b00; ee.f2 = 2'b00;
        ee.pc4 = v_pc4(16); ee.order = v_order(16, 5'd8, 5'd2, 5'd10);
        ee.ext = v_ext(16); ee.rd1 = v_rd1(16); ee.rd2 = v_rd2(16);
        ex_q.push_back(ee);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (ex_q.size() == 0 && st_q.size() == 0) n_pass++;
        else $display("FAIL drain got ex_left=%0d st_left=%0d exp 0/0", ex_q.size(), st_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
